// File: rtl/knob_counter.sv
// rtl/knob_counter.sv - groups encoder pulses into detents and steps a bounded setting
// Speed-accelerated steps; saturating or wrapping range.
module knob_counter #(
  parameter int WIDTH             = 8,
  parameter int MIN               = 0,
  parameter int MAX               = 255,
  parameter int INIT              = 0,
  parameter int PULSES_PER_DETENT = 4,
  parameter int STEP              = 1,
  parameter int FAST_STEP         = 10,
  parameter int FAST_WINDOW       = 2500000,
  parameter int WRAP              = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cw,
  input  logic             ccw,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             dir
);

  localparam int VW = WIDTH + 1;
  localparam int GW = $clog2(FAST_WINDOW + 2);

  localparam logic [VW-1:0]    MIN_V   = VW'(MIN);
  localparam logic [VW-1:0]    MAX_V   = VW'(MAX);
  localparam logic [VW-1:0]    RANGE_V = VW'(MAX - MIN + 1);
  localparam logic [VW-1:0]    STEP_V  = VW'(STEP);
  localparam logic [VW-1:0]    FAST_V  = VW'(FAST_STEP);
  localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);
  localparam logic [GW-1:0]    FW_G    = GW'(FAST_WINDOW);
  localparam logic signed [4:0] PPD_P  = 5'(PULSES_PER_DETENT);
  localparam logic signed [4:0] PPD_N  = 5'(-PULSES_PER_DETENT);

  logic signed [4:0] acc;
  logic signed [4:0] acc_inc;
  logic [GW-1:0]     gap;
  logic              valid;

  logic              up_det;
  logic              dn_det;
  logic              detent;
  logic              fast;
  logic [VW-1:0]     cur;
  logic [VW-1:0]     step;
  logic [VW-1:0]     sum;
  logic [VW-1:0]     nv;

  always_comb begin
    acc_inc = acc;
    if (cw && !ccw) begin
      acc_inc = acc + 5'sd1;
    end else if (ccw && !cw) begin
      acc_inc = acc - 5'sd1;
    end
    up_det = (acc_inc == PPD_P);
    dn_det = (acc_inc == PPD_N);
    detent = up_det || dn_det;

    // gap+1 is the number of edges since the last detent; equal to the window counts as slow
    fast = valid && (up_det == dir) && ((gap + GW'(1)) < FW_G);
    step = fast ? FAST_V : STEP_V;
    cur  = {1'b0, value};
    sum  = cur + step;

    nv = cur;
    if (up_det) begin
      if (sum > MAX_V) begin
        nv = (WRAP != 0) ? (sum - RANGE_V) : MAX_V;
      end else begin
        nv = sum;
      end
    end else if (dn_det) begin
      if (cur < (MIN_V + step)) begin
        nv = (WRAP != 0) ? (cur + RANGE_V - step) : MIN_V;
      end else begin
        nv = cur - step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value   <= INIT_V;
      changed <= 1'b0;
      dir     <= 1'b0;
      acc     <= '0;
      gap     <= FW_G;
      valid   <= 1'b0;
    end else if (clear) begin
      value   <= INIT_V;
      changed <= (value != INIT_V);
      acc     <= '0;
      gap     <= FW_G;
      valid   <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (detent) begin
        value   <= nv[WIDTH-1:0];
        changed <= (nv != cur);
        dir     <= up_det;
        valid   <= 1'b1;
        acc     <= '0;
        gap     <= '0;
      end else begin
        acc <= acc_inc;
        if (gap < FW_G) begin
          gap <= gap + GW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_knob_counter.sv
// tb/tb_knob_counter.sv - scoreboard bench for knob_counter
// Unit 0: 4 pulses/detent saturate; unit 1: 1 pulse/detent saturate MIN=2; unit 2: wrap 0..9.
module tb_knob_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [2:0] cw;
  logic [2:0] ccw;
  logic [2:0] clr;
  logic [7:0] val [3];
  logic [2:0] chg;
  logic [2:0] dr;

  int checks = 0;
  int passes = 0;

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [8:0] q2 [$];

  knob_counter #(.WIDTH(8), .MIN(0), .MAX(255), .INIT(0), .PULSES_PER_DETENT(4),
                 .STEP(1), .FAST_STEP(10), .FAST_WINDOW(100), .WRAP(0)) u_a (
    .clk(clk), .reset(rst[0]), .cw(cw[0]), .ccw(ccw[0]), .clear(clr[0]),
    .value(val[0]), .changed(chg[0]), .dir(dr[0]));

  knob_counter #(.WIDTH(8), .MIN(2), .MAX(255), .INIT(245), .PULSES_PER_DETENT(1),
                 .STEP(1), .FAST_STEP(10), .FAST_WINDOW(100), .WRAP(0)) u_s (
    .clk(clk), .reset(rst[1]), .cw(cw[1]), .ccw(ccw[1]), .clear(clr[1]),
    .value(val[1]), .changed(chg[1]), .dir(dr[1]));

  knob_counter #(.WIDTH(8), .MIN(0), .MAX(9), .INIT(0), .PULSES_PER_DETENT(1),
                 .STEP(1), .FAST_STEP(3), .FAST_WINDOW(100), .WRAP(1)) u_w (
    .clk(clk), .reset(rst[2]), .cw(cw[2]), .ccw(ccw[2]), .clear(clr[2]),
    .value(val[2]), .changed(chg[2]), .dir(dr[2]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic mon(input string name, input logic [8:0] act, input int have,
                     input logic [8:0] exp);
    checks++;
    if (have == 0)
      $display("FAIL %s unexpected changed: got dir=%0d value=%0d, expected no strobe",
               name, act[8], act[7:0]);
    else if (act == exp) passes++;
    else
      $display("FAIL %s strobe: got dir=%0d value=%0d, expected dir=%0d value=%0d",
               name, act[8], act[7:0], exp[8], exp[7:0]);
  endtask

  always @(negedge clk) begin
    if (chg[0]) begin
      mon("unit0", {dr[0], val[0]}, q0.size(), (q0.size() != 0) ? q0[0] : 9'd0);
      if (q0.size() != 0) void'(q0.pop_front());
    end
    if (chg[1]) begin
      mon("unit1", {dr[1], val[1]}, q1.size(), (q1.size() != 0) ? q1[0] : 9'd0);
      if (q1.size() != 0) void'(q1.pop_front());
    end
    if (chg[2]) begin
      mon("unit2", {dr[2], val[2]}, q2.size(), (q2.size() != 0) ? q2[0] : 9'd0);
      if (q2.size() != 0) void'(q2.pop_front());
    end
  end

  task automatic push(input int u, input bit d, input int v);
    logic [8:0] e;
    e = {d, 8'(v)};
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // kind: 0 = cw, 1 = ccw, 2 = both; called at a negedge, next call samples gap edges later
  task automatic pulse(input int u, input int kind, input int gap);
    if (kind != 1) cw[u] = 1'b1;
    if (kind != 0) ccw[u] = 1'b1;
    @(negedge clk);
    cw[u]  = 1'b0;
    ccw[u] = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // n pulses (spacing 5), the last one with trailing gap tail; expectation pushed before the last
  task automatic detent(input int u, input bit up, input int n, input int tail,
                        input int exp_v, input bit strobe);
    for (int i = 1; i < n; i++) pulse(u, up ? 0 : 1, 5);
    if (strobe) push(u, up, exp_v);
    pulse(u, up ? 0 : 1, tail);
  endtask

  task automatic do_clear(input int u, input bit with_cw);
    clr[u] = 1'b1;
    if (with_cw) cw[u] = 1'b1;
    @(negedge clk);
    clr[u] = 1'b0;
    cw[u]  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = '1;
    cw  = '0;
    ccw = '0;
    clr = '0;
    repeat (2) @(negedge clk);
    rst = '0;
    check("reset_value0", int'(val[0]), 0);
    check("reset_changed0", int'(chg[0]), 0);
    check("reset_dir0", int'(dr[0]), 0);
    check("reset_value1", int'(val[1]), 245);
    check("reset_value2", int'(val[2]), 0);
    repeat (2) @(negedge clk);

    // basic: 4 cw -> 1, then 3 more stay below a detent
    for (int i = 0; i < 3; i++) pulse(0, 0, 10);
    push(0, 1'b1, 1);
    pulse(0, 0, 10);
    for (int i = 0; i < 3; i++) pulse(0, 0, 10);
    check("basic_value", int'(val[0]), 1);
    check("basic_dir", int'(dr[0]), 1);

    // reset with acc=+3: no strobe, partial count lost
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("midreset_changed", int'(chg[0]), 0);
    check("midreset_value", int'(val[0]), 0);
    check("midreset_dir", int'(dr[0]), 0);
    repeat (3) @(negedge clk);

    // jitter cancel: +3 -1 +2 reaches +4 on the last pulse
    pulse(0, 0, 10); pulse(0, 0, 10); pulse(0, 0, 10);
    pulse(0, 1, 10); pulse(0, 0, 10);
    push(0, 1'b1, 1);
    pulse(0, 0, 10);
    // simultaneous pulses ignored, then acc=+3
    for (int i = 0; i < 3; i++) pulse(0, 2, 10);
    for (int i = 0; i < 3; i++) pulse(0, 0, 10);
    check("jitter_value", int'(val[0]), 1);

    // clear coincident with cw: value 1 -> INIT, dir holds, acc and valid cleared
    push(0, 1'b1, 0);
    do_clear(0, 1'b1);
    check("clear_value", int'(val[0]), 0);

    // acceleration with window 100
    detent(0, 1'b1, 4, 35, 1, 1'b1);
    detent(0, 1'b1, 4, 35, 11, 1'b1);
    detent(0, 1'b1, 4, 85, 21, 1'b1);
    detent(0, 1'b1, 4, 35, 22, 1'b1);
    detent(0, 1'b0, 4, 84, 21, 1'b1);
    detent(0, 1'b0, 4, 10, 11, 1'b1);
    detent(0, 1'b0, 4, 10, 1, 1'b1);
    check("accel_value", int'(val[0]), 1);
    check("accel_dir", int'(dr[0]), 0);

    // saturate at MAX through a 9-bit sum, then at MIN=2
    detent(1, 1'b1, 1, 10, 246, 1'b1);
    detent(1, 1'b1, 1, 10, 255, 1'b1);
    detent(1, 1'b1, 1, 10, 255, 1'b0);
    check("sat_max_value", int'(val[1]), 255);
    check("sat_max_dir", int'(dr[1]), 1);
    detent(1, 1'b0, 1, 10, 254, 1'b1);
    for (int k = 1; k <= 25; k++) detent(1, 1'b0, 1, 10, 254 - 10 * k, 1'b1);
    detent(1, 1'b0, 1, 10, 2, 1'b1);
    detent(1, 1'b0, 1, 10, 2, 1'b0);
    check("sat_min_value", int'(val[1]), 2);
    check("sat_min_dir", int'(dr[1]), 0);

    // wrap 0..9 with fast step 3, back-to-back detents
    detent(2, 1'b0, 1, 10, 9, 1'b1);
    detent(2, 1'b1, 1, 10, 0, 1'b1);
    detent(2, 1'b1, 1, 1, 3, 1'b1);
    detent(2, 1'b1, 1, 1, 6, 1'b1);
    detent(2, 1'b1, 1, 1, 9, 1'b1);
    detent(2, 1'b1, 1, 1, 2, 1'b1);
    detent(2, 1'b1, 1, 1, 5, 1'b1);
    detent(2, 1'b1, 1, 1, 8, 1'b1);
    detent(2, 1'b1, 1, 1, 1, 1'b1);
    detent(2, 1'b1, 1, 1, 4, 1'b1);
    detent(2, 1'b1, 1, 1, 7, 1'b1);
    detent(2, 1'b1, 1, 10, 0, 1'b1);
    detent(2, 1'b0, 1, 10, 9, 1'b1);
    detent(2, 1'b0, 1, 10, 6, 1'b1);
    push(2, 1'b0, 0);
    do_clear(2, 1'b0);
    do_clear(2, 1'b0);
    check("wrap_clear_value", int'(val[2]), 0);
    detent(2, 1'b0, 1, 10, 9, 1'b1);
    check("wrap_final_value", int'(val[2]), 9);

    repeat (5) @(negedge clk);
    check("unit0_pending", q0.size(), 0);
    check("unit1_pending", q1.size(), 0);
    check("unit2_pending", q2.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/knob_counter.md
# knob_counter

Consumes the single-cycle `cw`/`ccw` pulses produced by the quadrature encoder decoder and maintains a bounded user-setting register (e.g. volume, frequency index). It groups pulses into detents, applies optional speed-based acceleration, and clamps or wraps the value to a configured range. Its `value`/`changed` outputs feed the display and control logic downstream.

## Interface

Parameters:
- `WIDTH`, 8: width of `value`.
- `MIN`, 0: lowest legal value.
- `MAX`, 255: highest legal value. Requires `MIN <= MAX < 2**WIDTH`.
- `INIT`, 0: value loaded on reset and on `clear`. Requires `MIN <= INIT <= MAX`.
- `PULSES_PER_DETENT`, 4: same-direction net pulses that make one detent. Range 1..8.
- `STEP`, 1: increment per slow detent.
- `FAST_STEP`, 10: increment per fast detent. Requires `STEP` and `FAST_STEP` both `<= MAX-MIN`.
- `FAST_WINDOW`, 2500000: detent spacing in clk cycles below which a detent is "fast" (50 ms at 50 MHz).
- `WRAP`, 0: 0 = saturate at `MIN`/`MAX`; 1 = wrap around.

Ports:
- `clk`, input, 1: 50 MHz clock.
- `reset`, input, 1: synchronous, active-high reset.
- `cw`, input, 1: one-cycle clockwise pulse from the decoder.
- `ccw`, input, 1: one-cycle counter-clockwise pulse from the decoder.
- `clear`, input, 1: synchronous reload of `INIT`.
- `value`, output, `WIDTH`: current setting, registered.
- `changed`, output, 1: one-cycle strobe, high in the cycle after `value` takes a new value.
- `dir`, output, 1: direction of the last detent (1 = cw), registered.

## Operation

- Reset values:
  - `value` = `INIT`; `changed` = 0; `dir` = 0.
  - Sub-detent accumulator `acc` = 0.
  - Gap counter `gap` = `FAST_WINDOW`.
  - Last-direction valid flag = 0.
- Input qualification:
  - `cw && !ccw` gives `acc + 1`.
  - `ccw && !cw` gives `acc - 1`.
  - Both or neither: no change.
  - `acc` is a signed count spanning `±PULSES_PER_DETENT`.
- Detent:
  - When the update would make `acc` equal `+PULSES_PER_DETENT`, an up-detent occurs. When it would equal `-PULSES_PER_DETENT`, a down-detent occurs.
  - `acc` returns to 0 on the detent edge.
  - Opposite pulses cancel partial progress (jitter rejection). Example with 4 pulses per detent: +3, then −1, gives +2, not a reversal.
- Step selection:
  - `FAST_STEP` is used if `gap < FAST_WINDOW` AND the last-direction flag is valid AND the detent direction equals `dir`.
  - Otherwise `STEP` is used.
  - On every detent: `gap` ← 0, `dir` ← detent direction, valid flag ← 1.
- Gap counter: increments by 1 each cycle with no detent and saturates at `FAST_WINDOW`.
- Arithmetic:
  - Computed in `WIDTH+1` bits unsigned, no intermediate overflow.
  - Saturate mode: up gives `min(value+s, MAX)`; down gives `max(value−s, MIN)`. The down case is evaluated as `value < MIN+s ? MIN : value−s`.
  - Wrap mode: up gives `value+s > MAX ? value+s−(MAX−MIN+1) : value+s`; down gives `value < MIN+s ? value−s+(MAX−MIN+1) : value−s`.
- `changed`:
  - Asserted only when the new `value` differs from the old one.
  - A detent at a saturated limit still clears `acc` and updates `gap`/`dir`, but gives no strobe.
- `clear`:
  - Priority: `reset` > `clear` > pulses. Pulses in the `clear` cycle are dropped.
  - Loads `value` ← `INIT`, `acc` ← 0, `gap` ← `FAST_WINDOW`, valid flag ← 0.
  - `dir` holds.
  - `changed` is strobed iff the old `value` ≠ `INIT`.
- Reset mid-detent: partial `acc` is discarded, with no strobe.

## Timing

- Latency: a pulse sampled at edge N that completes a detent makes `value` and `dir` update at edge N. `changed` is high from edge N to edge N+1 (exactly one cycle).
- Back-to-back pulses on consecutive cycles are all counted. With `PULSES_PER_DETENT=1`, detents can occur every cycle, giving consecutive `changed` strobes.
- Fast-detent boundary: the second detent is fast if it is sampled fewer than `FAST_WINDOW` edges after the first. A spacing of exactly `FAST_WINDOW` cycles is slow.
- No handshake. Inputs are assumed synchronous one-cycle pulses; a held `cw` counts once per cycle.

## Test plan

- **Reset/basic:** reset, then 4 `cw` pulses spaced 10 cycles apart → `value` 0→1 on the 4th pulse's edge, `changed` one cycle wide, `dir`=1. Three more pulses → no change.
- **Jitter cancel:** `cw`×3, `ccw`×1, `cw`×2 → still value 0, `acc`=+4 reached on the last pulse → `value`=1. Simultaneous `cw`&`ccw` → ignored.
- **Acceleration** (`FAST_WINDOW`=100 for sim):
  - Up-detents spaced 50 cycles give values 1, 11, 21.
  - Next detent after 100 cycles → 22 (slow).
  - Reverse direction fast → step 1 (20→... first reversal uses `STEP`).
- **Saturate:** `MAX`=255, `value`=250, fast up-detent → 255 with `changed`. A further up-detent → 255, no `changed`. `MIN` side: 3 down fast → 0.
- **Wrap** (`WRAP`=1, `MIN`=0, `MAX`=9): `value`=9, up-detent → 0. `value`=0, down-detent → 9. `value`=7, fast `STEP` 10 is illegal, so use `FAST_STEP`=3: 7 up → 0.
- **Clear/reset priority:** `value`=5, `acc`=+3, `clear` coincident with a `cw` pulse → `value`=`INIT`=0, `changed`=1, `acc`=0; the next 3 `cw` → no detent. `reset` asserted with `acc`=+3 → `acc` cleared, `changed`=0.
